// File: rtl/inst_encoder_if.sv
// Request/write bus of the RV32I instruction encoder.
// Signal names carry the encoder's point of view: i_* flow into it, o_* out of it.
interface inst_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              i_clr;
    logic              i_op_vld;
    logic              o_op_rdy;
    logic [8:0]        i_key;
    logic [4:0]        i_rd;
    logic [4:0]        i_rs1;
    logic [4:0]        i_rs2;
    logic [31:0]       i_imm;
    logic              o_wr_en;
    logic              i_wr_rdy;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [31:0]       o_wr_data;
    logic [ADDR_W:0]   o_cnt;
    logic              o_full;
    logic              o_err;
    logic [8:0]        o_err_key;

    modport master (
        output i_clr, i_op_vld, i_key, i_rd, i_rs1, i_rs2, i_imm, i_wr_rdy,
        input  o_op_rdy, o_wr_en, o_wr_addr, o_wr_data, o_cnt, o_full, o_err, o_err_key
    );

    modport slave (
        input  i_clr, i_op_vld, i_key, i_rd, i_rs1, i_rs2, i_imm, i_wr_rdy,
        output o_op_rdy, o_wr_en, o_wr_addr, o_wr_data, o_cnt, o_full, o_err, o_err_key
    );
endinterface

// File: rtl/inst_encoder.sv
// Encodes {key, registers, immediate} requests into RV32I words and streams them
// into instruction memory at consecutive word addresses, one pending write at a time.
module inst_encoder #(
    parameter int ADDR_W = 8
) (
    input logic           i_clk,
    input logic           i_rst_n,
    inst_encoder_if.slave bus
);
    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam int                CW        = ADDR_W + 1;
    localparam logic [CW-1:0]     DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW:0]       DEPTH_OCC = (CW + 1)'(DEPTH);

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD} fmt_e;

    logic              b5;
    logic [2:0]        f3;
    logic [4:0]        opc;
    logic [31:0]       imm;
    fmt_e              fmt;
    logic              ok;
    logic [31:0]       word;
    logic              fits12, fits13, fits21;

    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nxt;
    logic [CW:0]       occ;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              err;
    logic [8:0]        err_key;
    logic              rdy;
    logic              accept;
    logic              commit;

    assign b5  = bus.i_key[8];
    assign f3  = bus.i_key[7:5];
    assign opc = bus.i_key[4:0];
    assign imm = bus.i_imm;

    // Signed range checks: every bit above the top payload bit must match the sign.
    assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

    always_comb begin
        fmt = FMT_BAD;
        case (opc)
            5'h0C: if (!b5 || f3 == 3'd0 || f3 == 3'd5) fmt = FMT_R;
            5'h04: begin
                if (f3 == 3'd1)      fmt = b5 ? FMT_BAD : FMT_SH;
                else if (f3 == 3'd5) fmt = FMT_SH;
                else                 fmt = FMT_I;
            end
            5'h00: if (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7) fmt = FMT_I;
            5'h19: if (f3 == 3'd0) fmt = FMT_I;
            5'h08: if (f3 <= 3'd2) fmt = FMT_S;
            5'h18: if (f3 != 3'd2 && f3 != 3'd3) fmt = FMT_B;
            5'h0D, 5'h05: fmt = FMT_U;
            5'h1B: fmt = FMT_J;
            default: fmt = FMT_BAD;
        endcase
    end

    always_comb begin
        word = 32'd0;
        ok   = 1'b0;
        case (fmt)
            FMT_R: begin
                word = {1'b0, b5, 5'd0, bus.i_rs2, bus.i_rs1, f3, bus.i_rd, opc, 2'b11};
                ok   = 1'b1;
            end
            FMT_I: begin
                word = {imm[11:0], bus.i_rs1, f3, bus.i_rd, opc, 2'b11};
                ok   = fits12;
            end
            FMT_SH: begin
                word = {1'b0, b5, 5'd0, imm[4:0], bus.i_rs1, f3, bus.i_rd, opc, 2'b11};
                ok   = ~(|imm[31:5]);
            end
            FMT_S: begin
                word = {imm[11:5], bus.i_rs2, bus.i_rs1, f3, imm[4:0], opc, 2'b11};
                ok   = fits12;
            end
            FMT_B: begin
                word = {imm[12], imm[10:5], bus.i_rs2, bus.i_rs1, f3, imm[4:1], imm[11], opc, 2'b11};
                ok   = fits13 & ~imm[0];
            end
            FMT_U: begin
                word = {imm[31:12], bus.i_rd, opc, 2'b11};
                ok   = ~(|imm[11:0]);
            end
            FMT_J: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.i_rd, opc, 2'b11};
                ok   = fits21 & ~imm[0];
            end
            default: begin
                word = 32'd0;
                ok   = 1'b0;
            end
        endcase
    end

    // Handshakes: a request transfers on i_op_vld && o_op_rdy, a write commits on
    // o_wr_en && i_wr_rdy; o_op_rdy only rises when the pending slot frees this cycle
    // and the memory still has room for the word already in flight plus a new one.
    assign occ    = {1'b0, cnt} + {{CW{1'b0}}, wr_en};
    assign rdy    = i_rst_n && !bus.i_clr && (occ < DEPTH_OCC) && (!wr_en || bus.i_wr_rdy);
    assign accept = bus.i_op_vld && rdy;
    assign commit = wr_en && bus.i_wr_rdy;
    assign cnt_nxt = cnt + CW'(commit);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt     <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            err     <= 1'b0;
            err_key <= '0;
        end else if (bus.i_clr) begin
            cnt     <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            err     <= 1'b0;
            err_key <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (accept && ok) begin
                wr_en   <= 1'b1;
                wr_addr <= cnt_nxt[ADDR_W-1:0];
                wr_data <= word;
            end else if (commit) begin
                wr_en <= 1'b0;
            end
            if (accept && !ok) begin
                err <= 1'b1;
                if (!err) err_key <= bus.i_key;
            end
        end
    end

    assign bus.o_op_rdy  = rdy;
    assign bus.o_wr_en   = wr_en;
    assign bus.o_wr_addr = wr_addr;
    assign bus.o_wr_data = wr_data;
    assign bus.o_cnt     = cnt;
    assign bus.o_full    = (cnt == DEPTH_CNT);
    assign bus.o_err     = err;
    assign bus.o_err_key = err_key;
endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: known-answer vector table, hand sequences for stall/full/reset,
// then random traffic checked cycle by cycle against a queue-based reference model.
module tb_inst_encoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus shared by both instances ----------------
    logic        sel2 = 1'b0;
    logic        clr = 1'b0, vld = 1'b0, wr_rdy = 1'b1;
    logic [8:0]  key = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0] imm = '0;

    inst_encoder_if #(.ADDR_W(8)) bus8();
    inst_encoder_if #(.ADDR_W(2)) bus2();

    inst_encoder #(.ADDR_W(8)) dut8 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus8));
    inst_encoder #(.ADDR_W(2)) dut2 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus2));

    assign bus8.i_clr = clr;            assign bus2.i_clr = clr;
    assign bus8.i_op_vld = vld && !sel2; assign bus2.i_op_vld = vld && sel2;
    assign bus8.i_key = key;            assign bus2.i_key = key;
    assign bus8.i_rd = rd;              assign bus2.i_rd = rd;
    assign bus8.i_rs1 = rs1;            assign bus2.i_rs1 = rs1;
    assign bus8.i_rs2 = rs2;            assign bus2.i_rs2 = rs2;
    assign bus8.i_imm = imm;            assign bus2.i_imm = imm;
    assign bus8.i_wr_rdy = wr_rdy;      assign bus2.i_wr_rdy = wr_rdy;

    logic        act_rdy, act_wr_en, act_full, act_err;
    logic [8:0]  act_addr, act_cnt, act_err_key;
    logic [31:0] act_data;
    assign act_rdy     = sel2 ? bus2.o_op_rdy  : bus8.o_op_rdy;
    assign act_wr_en   = sel2 ? bus2.o_wr_en   : bus8.o_wr_en;
    assign act_full    = sel2 ? bus2.o_full    : bus8.o_full;
    assign act_err     = sel2 ? bus2.o_err     : bus8.o_err;
    assign act_addr    = sel2 ? {7'd0, bus2.o_wr_addr} : {1'b0, bus8.o_wr_addr};
    assign act_cnt     = sel2 ? {6'd0, bus2.o_cnt} : bus8.o_cnt;
    assign act_err_key = sel2 ? bus2.o_err_key : bus8.o_err_key;
    assign act_data    = sel2 ? bus2.o_wr_data : bus8.o_wr_data;

    // ---------------- scoreboard / reference model ----------------
    int          n_checks = 0;
    int          n_fail = 0;
    int          depth = 256;
    int          m_cnt = 0;
    int          m_addr = 0;
    logic        m_err = 1'b0;
    logic [8:0]  m_err_key = '0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Legal {funct7[5],funct3} combinations per opcode, one bit per combination.
    function automatic bit key_ok(input logic [8:0] k);
        logic [15:0] m;
        case (k[4:0])
            5'h0C: m = 16'h21FF;
            5'h04: m = 16'hFDFF;
            5'h00: m = 16'h3737;
            5'h08: m = 16'h0707;
            5'h18: m = 16'hF3F3;
            5'h19: m = 16'h0101;
            5'h1B, 5'h0D, 5'h05: m = 16'hFFFF;
            default: m = 16'h0000;
        endcase
        return m[{k[8], k[7:5]}];
    endfunction

    function automatic void ref_encode(input logic [8:0] k, input logic [4:0] d, s1, s2,
                                       input logic [31:0] im, output bit ok, output logic [31:0] w);
        logic [31:0] op, dd, r1, r2, f3, b5s;
        int sv;
        op  = {25'd0, k[4:0], 2'b11};
        dd  = 32'(d) << 7;
        r1  = 32'(s1) << 15;
        r2  = 32'(s2) << 20;
        f3  = 32'(k[7:5]) << 12;
        b5s = 32'(k[8]) << 30;
        sv  = $signed(im);
        ok  = key_ok(k);
        w   = 32'd0;
        if (ok) begin
            case (k[4:0])
                5'h0C: w = op | dd | f3 | r1 | r2 | b5s;
                5'h04: begin
                    if (k[7:5] == 3'd1 || k[7:5] == 3'd5) begin
                        ok = (im < 32);
                        w  = op | dd | f3 | r1 | (im << 20) | b5s;
                    end else begin
                        ok = (sv >= -2048 && sv <= 2047);
                        w  = op | dd | f3 | r1 | (im << 20);
                    end
                end
                5'h00, 5'h19: begin
                    ok = (sv >= -2048 && sv <= 2047);
                    w  = op | dd | f3 | r1 | (im << 20);
                end
                5'h08: begin
                    ok = (sv >= -2048 && sv <= 2047);
                    w  = op | f3 | r1 | r2 | (((im >> 5) & 32'h7F) << 25) | ((im & 32'h1F) << 7);
                end
                5'h18: begin
                    ok = (sv >= -4096 && sv <= 4095 && (im % 2) == 0);
                    w  = op | f3 | r1 | r2 | (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25)
                         | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 1) << 7);
                end
                5'h0D, 5'h05: begin
                    ok = ((im & 32'hFFF) == 0);
                    w  = op | dd | (im & 32'hFFFFF000);
                end
                default: begin
                    ok = (sv >= -(1 << 20) && sv < (1 << 20) && (im % 2) == 0);
                    w  = op | dd | (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                         | (((im >> 11) & 1) << 20) | (((im >> 12) & 32'hFF) << 12);
                end
            endcase
        end
    endfunction

    function automatic bit model_rdy();
        return rst_n && !clr && (m_cnt + exp_q.size() < depth) && (exp_q.size() == 0 || wr_rdy);
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_addr = 0; m_err = 1'b0; m_err_key = '0;
        exp_q.delete();
    endtask

    task automatic model_step(input bit acc, input bit ok, input logic [31:0] w);
        if (clr) begin
            model_reset();
        end else begin
            if (exp_q.size() != 0 && wr_rdy) begin
                void'(exp_q.pop_front());
                m_cnt++;
            end
            if (acc && ok) begin
                exp_q.push_back(w);
                m_addr = m_cnt % depth;
            end else if (acc) begin
                if (!m_err) m_err_key = key;
                m_err = 1'b1;
            end
        end
    endtask

    task automatic check_state();
        check("wr_en", 32'(act_wr_en), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("wr_addr", 32'(act_addr), 32'(m_addr));
            check("wr_data", act_data, exp_q[0]);
        end
        check("cnt", 32'(act_cnt), 32'(m_cnt));
        check("full", 32'(act_full), 32'(m_cnt == depth));
        check("err", 32'(act_err), 32'(m_err));
        check("err_key", 32'(act_err_key), 32'(m_err_key));
    endtask

    // ---------------- driver tasks ----------------
    task automatic half_cycle();
        bit exp_rdy, acc, ok;
        logic [31:0] w;
        exp_rdy = model_rdy();
        check("op_rdy", 32'(act_rdy), 32'(exp_rdy));
        acc = vld && exp_rdy;
        ref_encode(key, rd, rs1, rs2, imm, ok, w);
        @(posedge clk);
        model_step(acc, ok, w);
        #1 check_state();
    endtask

    task automatic cycle();
        @(negedge clk);
        half_cycle();
    endtask

    task automatic set_req(input logic [8:0] k, input logic [4:0] d, s1, s2, input logic [31:0] im);
        vld = 1'b1; key = k; rd = d; rs1 = s1; rs2 = s2; imm = im;
    endtask

    task automatic do_reset(input bit use2);
        rst_n = 1'b0; sel2 = use2; depth = use2 ? 4 : 256;
        clr = 1'b0; vld = 1'b0; wr_rdy = 1'b1;
        @(posedge clk);
        #1;
        check("rst_wr_en", 32'(act_wr_en), 32'd0);
        check("rst_wr_addr", 32'(act_addr), 32'd0);
        check("rst_wr_data", act_data, 32'd0);
        check("rst_cnt", 32'(act_cnt), 32'd0);
        check("rst_full", 32'(act_full), 32'd0);
        check("rst_err", 32'(act_err), 32'd0);
        check("rst_err_key", 32'(act_err_key), 32'd0);
        check("rst_op_rdy", 32'(act_rdy), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] pick_key();
        logic [8:0] k;
        k = 9'($urandom_range(0, 511));
        if ($urandom_range(0, 9) < 8) begin
            for (int t = 0; t < 64 && !key_ok(k); t++) k = 9'($urandom_range(0, 511));
        end
        return k;
    endfunction

    function automatic logic [31:0] pick_imm();
        case ($urandom_range(0, 4))
            0: return 32'($urandom_range(0, 127)) - 32'd64;
            1: return $urandom;
            2: return {20'($urandom), 12'd0};
            3: return (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
            default: return 32'($urandom_range(0, 31));
        endcase
    endfunction

    task automatic rand_run(input int n);
        for (int i = 0; i < n; i++) begin
            clr    = ($urandom_range(0, 59) == 0);
            vld    = ($urandom_range(0, 3) != 0);
            wr_rdy = ($urandom_range(0, 3) != 0);
            key    = pick_key();
            rd     = 5'($urandom_range(0, 31));
            rs1    = 5'($urandom_range(0, 31));
            rs2    = 5'($urandom_range(0, 31));
            imm    = pick_imm();
            cycle();
        end
        clr = 1'b0; vld = 1'b0;
    endtask

    // ---------------- known-answer table ----------------
    typedef struct {
        logic [8:0]  key;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        bit          ok;
        logic [31:0] word;
    } vec_t;
    vec_t vecs[20];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{9'h004, 5'd1, 5'd0, 5'd0, 32'd5,          1'b1, 32'h00500093};
        vecs[1]  = '{9'h10C, 5'd3, 5'd1, 5'd2, 32'd0,          1'b1, 32'h402081B3};
        vecs[2]  = '{9'h018, 5'd5, 5'd1, 5'd2, 32'hFFFFFFF8,   1'b1, 32'hFE208CE3};
        vecs[3]  = '{9'h00D, 5'd5, 5'd3, 5'd0, 32'h12345000,   1'b1, 32'h123452B7};
        vecs[4]  = '{9'h01B, 5'd1, 5'd0, 5'd0, 32'd8,          1'b1, 32'h008000EF};
        vecs[5]  = '{9'h048, 5'd7, 5'd1, 5'd2, 32'd12,         1'b1, 32'h0020A623};
        vecs[6]  = '{9'h1A4, 5'd4, 5'd5, 5'd9, 32'd3,          1'b1, 32'h4032D213};
        vecs[7]  = '{9'h104, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF,   1'b1, 32'hFFF00093};
        vecs[8]  = '{9'h1CC, 5'd1, 5'd1, 5'd1, 32'd0,          1'b0, 32'd0};
        vecs[9]  = '{9'h01B, 5'd1, 5'd0, 5'd0, 32'd3,          1'b0, 32'd0};
        vecs[10] = '{9'h004, 5'd1, 5'd0, 5'd0, 32'd2048,       1'b0, 32'd0};
        vecs[11] = '{9'h004, 5'd1, 5'd0, 5'd0, 32'hFFFFF800,   1'b1, 32'h80000093};
        vecs[12] = '{9'h024, 5'd1, 5'd1, 5'd0, 32'd32,         1'b0, 32'd0};
        vecs[13] = '{9'h005, 5'd1, 5'd0, 5'd0, 32'h00001001,   1'b0, 32'd0};
        vecs[14] = '{9'h018, 5'd0, 5'd1, 5'd2, 32'd4096,       1'b0, 32'd0};
        vecs[15] = '{9'h019, 5'd1, 5'd2, 5'd0, 32'd0,          1'b1, 32'h000100E7};
        vecs[16] = '{9'h039, 5'd1, 5'd2, 5'd0, 32'd0,          1'b0, 32'd0};
        vecs[17] = '{9'h040, 5'd5, 5'd6, 5'd0, 32'hFFFFFFFC,   1'b1, 32'hFFC32283};
        vecs[18] = '{9'h01F, 5'd1, 5'd1, 5'd1, 32'd0,          1'b0, 32'd0};
        vecs[19] = '{9'h018, 5'd0, 5'd1, 5'd2, 32'hFFFFF000,   1'b1, 32'h80208063};

        do_reset(1'b0);

        // Table: each vector gets a fresh clear so address and error start from zero.
        foreach (vecs[i]) begin
            clr = 1'b1; vld = 1'b0; wr_rdy = 1'b1;
            cycle();
            clr = 1'b0;
            set_req(vecs[i].key, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            cycle();
            vld = 1'b0;
            if (vecs[i].ok) begin
                check($sformatf("vec%0d_wr_en", i), 32'(act_wr_en), 32'd1);
                check($sformatf("vec%0d_word", i), act_data, vecs[i].word);
                check($sformatf("vec%0d_addr", i), 32'(act_addr), 32'd0);
            end else begin
                check($sformatf("vec%0d_wr_en", i), 32'(act_wr_en), 32'd0);
                check($sformatf("vec%0d_err", i), 32'(act_err), 32'd1);
                check($sformatf("vec%0d_err_key", i), 32'(act_err_key), 32'(vecs[i].key));
            end
        end

        // Sticky error keeps the first rejected key; a commit count must not move.
        do_reset(1'b0);
        set_req(9'h1CC, 5'd1, 5'd2, 5'd3, 32'd0);
        cycle();
        set_req(9'h01B, 5'd1, 5'd0, 5'd0, 32'd3);
        cycle();
        vld = 1'b0;
        cycle();
        check("sticky_err", 32'(act_err), 32'd1);
        check("sticky_err_key", 32'(act_err_key), 32'h1CC);
        check("sticky_cnt", 32'(act_cnt), 32'd0);
        check("sticky_no_write", 32'(act_wr_en), 32'd0);

        // Back-pressure: the pending write holds for three stalled cycles.
        do_reset(1'b0);
        set_req(9'h10C, 5'd3, 5'd1, 5'd2, 32'd0);
        cycle();
        set_req(9'h018, 5'd5, 5'd1, 5'd2, 32'hFFFFFFF8);
        wr_rdy = 1'b0;
        for (int s = 0; s < 3; s++) begin
            cycle();
            check("stall_wr_en", 32'(act_wr_en), 32'd1);
            check("stall_data", act_data, 32'h402081B3);
            check("stall_addr", 32'(act_addr), 32'd0);
            check("stall_cnt", 32'(act_cnt), 32'd0);
            check("stall_rdy", 32'(act_rdy), 32'd0);
        end
        wr_rdy = 1'b1;
        cycle();
        check("release_cnt", 32'(act_cnt), 32'd1);
        check("release_data", act_data, 32'hFE208CE3);
        check("release_addr", 32'(act_addr), 32'd1);
        set_req(9'h004, 5'd1, 5'd0, 5'd0, 32'd5);
        repeat (6) cycle();
        check("stream_cnt", 32'(act_cnt), 32'd7);
        check("stream_addr", 32'(act_addr), 32'd7);

        // Small memory: fill, then clear reopens at address 0.
        do_reset(1'b1);
        set_req(9'h004, 5'd1, 5'd0, 5'd0, 32'd5);
        repeat (5) cycle();
        check("full_cnt", 32'(act_cnt), 32'd4);
        check("full_flag", 32'(act_full), 32'd1);
        check("full_rdy", 32'(act_rdy), 32'd0);
        cycle();
        check("full_hold_cnt", 32'(act_cnt), 32'd4);
        clr = 1'b1;
        cycle();
        check("clr_cnt", 32'(act_cnt), 32'd0);
        check("clr_full", 32'(act_full), 32'd0);
        clr = 1'b0;
        cycle();
        check("clr_next_addr", 32'(act_addr), 32'd0);
        check("clr_next_wr_en", 32'(act_wr_en), 32'd1);
        vld = 1'b0;
        cycle();

        // Asynchronous reset drops a stalled pending write without committing it.
        do_reset(1'b0);
        set_req(9'h004, 5'd1, 5'd0, 5'd0, 32'd5);
        cycle();
        cycle();
        vld = 1'b0; wr_rdy = 1'b0;
        cycle();
        check("pre_rst_cnt", 32'(act_cnt), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_wr_en", 32'(act_wr_en), 32'd0);
        check("arst_cnt", 32'(act_cnt), 32'd0);
        check("arst_rdy", 32'(act_rdy), 32'd0);
        check("arst_data", act_data, 32'd0);
        model_reset();
        @(negedge clk);
        check("arst_hold_cnt", 32'(act_cnt), 32'd0);
        rst_n = 1'b1; wr_rdy = 1'b1;
        set_req(9'h004, 5'd2, 5'd0, 5'd0, 32'd7);
        #1;
        half_cycle();
        check("post_rst_wr_en", 32'(act_wr_en), 32'd1);
        check("post_rst_data", act_data, 32'h00700113);
        check("post_rst_addr", 32'(act_addr), 32'd0);
        vld = 1'b0;

        // Random traffic on both memory sizes.
        do_reset(1'b0);
        rand_run(1500);
        do_reset(1'b1);
        rand_run(1500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
